// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state type and funct3 decode for the divide issue controller
package div_pkg;

    localparam int OP_W = 4;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [OP_W-1:0] OP_DIV  = 4'b1000;
    localparam logic [OP_W-1:0] OP_DIVU = 4'b0100;
    localparam logic [OP_W-1:0] OP_REM  = 4'b0010;
    localparam logic [OP_W-1:0] OP_REMU = 4'b0001;
    localparam logic [OP_W-1:0] OP_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_DRAIN
    } div_state_e;

    // OP_NONE marks a funct3 that is not a divide-class encoding
    function automatic logic [OP_W-1:0] f3_to_op(input logic [2:0] f3);
        case (f3)
            F3_DIV:  return OP_DIV;
            F3_DIVU: return OP_DIVU;
            F3_REM:  return OP_REM;
            F3_REMU: return OP_REMU;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// rtl/div_result_cache.sv - single-entry (rs1, rs2, op) -> result cache with combinational hit
module div_result_cache
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     lookup_rs1_i,
    input  logic [31:0]     lookup_rs2_i,
    input  logic [OP_W-1:0] lookup_op_i,
    output logic            hit_o,
    output logic [31:0]     hit_data_o,
    input  logic            wr_en_i,
    input  logic [31:0]     wr_rs1_i,
    input  logic [31:0]     wr_rs2_i,
    input  logic [OP_W-1:0] wr_op_i,
    input  logic [31:0]     wr_data_i
);

    logic            r_valid;
    logic [31:0]     r_rs1;
    logic [31:0]     r_rs2;
    logic [OP_W-1:0] r_op;
    logic [31:0]     r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_op    <= '0;
            r_data  <= '0;
        end else if (wr_en_i) begin
            r_valid <= 1'b1;
            r_rs1   <= wr_rs1_i;
            r_rs2   <= wr_rs2_i;
            r_op    <= wr_op_i;
            r_data  <= wr_data_i;
        end
    end

    // The op is part of the tag, so DIV and REM on equal operands never alias
    assign hit_o      = r_valid && (r_rs1 == lookup_rs1_i) && (r_rs2 == lookup_rs2_i)
                        && (r_op == lookup_op_i);
    assign hit_data_o = r_data;

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - divide-class issue controller: divider handshake, stall, writeback, result cache
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [31:0]     rs1_i,
    input  logic [31:0]     rs2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            div_start_o,
    output logic [OP_W-1:0] div_op_o,
    output logic [31:0]     div_dividend_o,
    output logic [31:0]     div_divisor_o,
    input  logic [31:0]     div_result_i,
    input  logic            div_ready_i,
    output logic            hold_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_addr_o,
    output logic [31:0]     wb_data_o,
    output logic            busy_o
);

    div_state_e      r_state;
    div_state_e      w_state_nxt;
    logic [31:0]     r_rs1;
    logic [31:0]     r_rs2;
    logic [4:0]      r_rd;
    logic [OP_W-1:0] r_op;
    logic [4:0]      r_wb_addr;
    logic [31:0]     r_wb_data;

    logic [OP_W-1:0] w_req_op;
    logic            w_req_ok;
    logic            w_hit;
    logic [31:0]     w_hit_data;
    logic            w_load_req;
    logic            w_load_hit;
    logic            w_load_div;
    logic            w_cache_we;

    assign w_req_op = f3_to_op(funct3_i);
    assign w_req_ok = req_valid_i && !flush_i && (w_req_op != OP_NONE);

    generate
        if (CACHE_EN != 0) begin : g_cache
            div_result_cache u_cache (
                .clk          (clk),
                .rst          (rst),
                .lookup_rs1_i (rs1_i),
                .lookup_rs2_i (rs2_i),
                .lookup_op_i  (w_req_op),
                .hit_o        (w_hit),
                .hit_data_o   (w_hit_data),
                .wr_en_i      (w_cache_we),
                .wr_rs1_i     (r_rs1),
                .wr_rs2_i     (r_rs2),
                .wr_op_i      (r_op),
                .wr_data_i    (div_result_i)
            );
        end else begin : g_no_cache
            assign w_hit      = 1'b0;
            assign w_hit_data = '0;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        hold_o      = 1'b0;
        div_start_o = 1'b0;
        wb_we_o     = 1'b0;
        w_load_req  = 1'b0;
        w_load_hit  = 1'b0;
        w_load_div  = 1'b0;
        w_cache_we  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_ok) begin
                    hold_o     = 1'b1;
                    w_load_req = 1'b1;
                    if (w_hit) begin
                        w_load_hit  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                hold_o = 1'b1;
                // The divider is already idle in its ready cycle; start must fall then or it relaunches
                div_start_o = !div_ready_i && !flush_i;
                if (div_ready_i) begin
                    w_cache_we = 1'b1;
                    if (flush_i) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_load_div  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else if (flush_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                wb_we_o     = !flush_i && (r_wb_addr != 5'd0);
                w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_op      <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_req) begin
                r_rs1 <= rs1_i;
                r_rs2 <= rs2_i;
                r_rd  <= rd_addr_i;
                r_op  <= w_req_op;
            end
            // Writeback registers only move on entry to DONE so they hold between writebacks
            if (w_load_hit) begin
                r_wb_addr <= rd_addr_i;
                r_wb_data <= w_hit_data;
            end else if (w_load_div) begin
                r_wb_addr <= r_rd;
                r_wb_data <= div_result_i;
            end
        end
    end

    assign div_op_o       = r_op;
    assign div_dividend_o = r_rs1;
    assign div_divisor_o  = r_rs2;
    assign wb_addr_o      = r_wb_addr;
    assign wb_data_o      = r_wb_data;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl with a behavioural divider and result model
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        div_start_o;
    logic [3:0]  div_op_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [31:0] div_result_i;
    logic        div_ready_i;
    logic        hold_o;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        busy_o;

    always #5 clk = ~clk;

    div_issue_ctrl #(.CACHE_EN(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .div_start_o    (div_start_o),
        .div_op_o       (div_op_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_result_i   (div_result_i),
        .div_ready_i    (div_ready_i),
        .hold_o         (hold_o),
        .wb_we_o        (wb_we_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          hit;
        int          req_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ready_cyc = -100;
    int          lat_min = 2;
    int          lat_max = 8;

    bit          c_valid = 1'b0;
    logic [2:0]  c_f3;
    logic [31:0] c_a;
    logic [31:0] c_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension results, including divide-by-zero and signed overflow
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int  sa;
        int  sb_;
        bit  ovf;
        sa  = a;
        sb_ = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb_));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb_));
            3'b111:  return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] f3_onehot(input logic [2:0] f3);
        return 4'b0001 << (3'd7 - f3);
    endfunction

    function automatic logic [2:0] onehot_f3(input logic [3:0] op);
        case (op)
            4'b1000: return 3'b100;
            4'b0100: return 3'b101;
            4'b0010: return 3'b110;
            4'b0001: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural iterative divider: runs while start is high, aborts if start drops
    initial begin
        bit          running;
        int          left;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        running      = 1'b0;
        left         = 0;
        div_ready_i  = 1'b0;
        div_result_i = '0;
        forever begin
            @(posedge clk);
            #2;
            div_ready_i = 1'b0;
            if (rst || !div_start_o) begin
                running = 1'b0;
            end else if (!running) begin
                running = 1'b1;
                left    = $urandom_range(lat_max, lat_min);
                a       = div_dividend_o;
                b       = div_divisor_o;
                f3      = onehot_f3(div_op_o);
            end else begin
                left--;
                if (left == 0) begin
                    div_result_i = ref_div(f3, a, b);
                    div_ready_i  = 1'b1;
                    running      = 1'b0;
                    #1;
                    chk("start_low_in_ready", 32'(div_start_o), 32'd0);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (div_ready_i) last_ready_cyc = cyc;
            if (wb_we_o) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_we_o), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wb_addr", 32'(wb_addr_o), 32'(mon_e.rd));
                    chk("wb_data", wb_data_o, mon_e.data);
                    chk("hold_in_wb", 32'(hold_o), 32'd0);
                    chk("wb_latency", 32'(cyc),
                        32'(mon_e.hit ? mon_e.req_cyc + 1 : last_ready_cyc + 1));
                end
            end
        end
    end

    // Called and returns at one time unit after a rising edge
    task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        bit          hit;
        bit          saw_start;
        bit          done;
        logic [31:0] res;
        res = ref_div(f3, a, b);
        hit = c_valid && (c_f3 == f3) && (c_a == a) && (c_b == b);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        rs1_i       = a;
        rs2_i       = b;
        rd_addr_i   = rd;
        if (rd != 0) sb.push_back('{rd: rd, data: res, hit: hit, req_cyc: cyc});
        saw_start = 1'b0;
        done      = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (div_start_o && !saw_start) begin
                saw_start = 1'b1;
                chk("div_op", 32'(div_op_o), 32'(f3_onehot(f3)));
            end
            if (busy_o && !hold_o) done = 1'b1;
        end
        chk("req_complete", 32'(done), 32'd1);
        chk("divider_used", 32'(saw_start), 32'(!hit));
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        if (!hit) begin
            c_valid = 1'b1;
            c_f3    = f3;
            c_a     = a;
            c_b     = b;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(div_start_o), 32'd0);
        chk({tag, "_op"}, 32'(div_op_o), 32'd0);
        chk({tag, "_dividend"}, div_dividend_o, 32'd0);
        chk({tag, "_divisor"}, div_divisor_o, 32'd0);
        chk({tag, "_hold"}, 32'(hold_o), 32'd0);
        chk({tag, "_wb_we"}, 32'(wb_we_o), 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr_o), 32'd0);
        chk({tag, "_wb_data"}, wb_data_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pool [6];
        pool = '{32'd0, 32'd1, 32'd7, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_req(3'b101, 32'd100, 32'd7, 5'd5);
        run_req(3'b101, 32'd100, 32'd7, 5'd5);
        run_req(3'b111, 32'd100, 32'd7, 5'd6);
        run_req(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_req(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_req(3'b100, 32'd1234, 32'd0, 5'd10);
        run_req(3'b111, 32'd9, 32'd0, 5'd11);

        // Flush ten cycles into a long divide
        lat_min = 30;
        lat_max = 30;
        req_valid_i = 1'b1;
        funct3_i    = 3'b100;
        rs1_i       = 32'd1000;
        rs2_i       = 32'd3;
        rd_addr_i   = 5'd9;
        @(posedge clk);
        #1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("busy_start_before_flush", 32'(div_start_o), 32'd1);
        @(posedge clk);
        #1;
        flush_i     = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_start_low", 32'(div_start_o), 32'd0);
        chk("flush_busy", 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("drain_busy", 32'(busy_o), 32'd1);
        chk("drain_hold", 32'(hold_o), 32'd0);
        chk("drain_start", 32'(div_start_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_drain_idle", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        lat_min = 2;
        lat_max = 8;
        run_req(3'b111, 32'd9, 32'd0, 5'd12);
        run_req(3'b101, 32'd20, 32'd3, 5'd13);

        // Asynchronous reset in the middle of a divide
        lat_min = 30;
        lat_max = 30;
        req_valid_i = 1'b1;
        funct3_i    = 3'b100;
        rs1_i       = 32'd55;
        rs2_i       = 32'd4;
        rd_addr_i   = 5'd3;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rst         = 1'b1;
        #1;
        chk_all_zero("midbusy_reset");
        c_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lat_min = 2;
        lat_max = 8;
        run_req(3'b101, 32'd20, 32'd3, 5'd4);
        run_req(3'b100, 32'd77, 32'd5, 5'd0);

        // Invalid funct3 takes no action
        req_valid_i = 1'b1;
        funct3_i    = 3'b010;
        @(negedge clk);
        chk("invalid_f3_hold", 32'(hold_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("invalid_f3_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9, 0) < 3 && c_valid) begin
                f3 = c_f3;
                a  = c_a;
                b  = c_b;
            end else begin
                f3 = 3'b100 | 3'($urandom_range(3, 0));
                a  = ($urandom_range(3, 0) == 0) ? $urandom : pool[$urandom_range(5, 0)];
                b  = ($urandom_range(3, 0) == 0) ? $urandom : pool[$urandom_range(5, 0)];
            end
            run_req(f3, a, b, 5'($urandom_range(31, 0)));
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
